mpadd_seq: RTL and testbench
============================

Name: mpadd_seq

Overview:
- Multi-precision add sequencer built around the team's existing 8-bit carry-lookahead adder (`cla`).
- Accepts two 8*NBYTES-bit operands over a valid/ready handshake.
- Adds them byte-serially, least significant byte first, through a single `cla` instance, registering the carry between bytes.
- Presents the full-width sum, carry-out and signed overflow over a valid/ready handshake.
- Sits between a requester (ALU/bignum front-end) and the shared 8-bit adder datapath.

Parameters:
- NBYTES, default 4: operand width in bytes; legal range ≥1; data width W = 8*NBYTES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for byte 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  sum, modulo 2^W.
- out_cout  out  1  carry out of the MSB.
- out_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0; internal operand, carry and index registers cleared.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_a, in_b and in_cin into carry_reg, set idx=0, go to RUN.
  - RUN: each cycle, `cla` gets A=a_reg[8*idx+:8], B=b_reg[8*idx+:8], Cin=carry_reg. Its Sum is written to sum_reg[8*idx+:8] and its Cout to carry_reg. Then idx increments. When idx==NBYTES-1, the write completes and the state goes to DONE.
  - DONE: out_valid=1. Hold out_sum, out_cout and out_ovf stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Handshake and latency:
  - in_ready is 0 in RUN and DONE; in_valid there is ignored.
  - No accept in the same cycle as a DONE→IDLE hand-off; throughput is one op per NBYTES+2 cycles.
  - Latency: out_valid rises NBYTES rising edges after the accepting edge. With NBYTES=1 there is one RUN cycle.
- Result rules:
  - out_cout = final carry_reg.
  - out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is B after any inversion (see Optional Feature).
- Index counter is $clog2(NBYTES) bits, minimum 1, and never exceeds NBYTES-1.
- out_sum, out_cout and out_ovf are registered outputs. Outside DONE they hold their last value; they are undefined to the consumer while out_valid=0.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro MPADD_SUB_EN. When defined:
  - Adds input port in_sub (1 bit), captured on accept.
  - in_sub=1: every B byte is inverted before `cla` and the initial carry is forced to 1, ignoring in_cin. The result is A−B, and out_cout=1 means no borrow.
  - in_sub=0: plain addition.
- When undefined: port in_sub is absent and the block is add-only; logic is identical to in_sub=0.

Decomposition:
- Package mpadd_pkg holds:
  - BYTE_W=8;
  - the state enum typedef {IDLE, RUN, DONE} (2 bits);
  - the function computing the index width.
- Sub-module: the existing `cla`, instantiated once, unmodified. No other sub-modules.

Test Plan:
- NBYTES=4, a=0x0000_00FF, b=0x0000_0001, cin=0 → out_sum=0x0000_0100, cout=0, ovf=0, out_valid 4 edges after accept.
- a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0x0000_0000, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0. Drive in_valid with new operands meanwhile → ignored. Release out_ready → IDLE next edge.
- Assert rst_n=0 during RUN at idx=2 → all outputs at reset values immediately. After release, a fresh op 0x1234_5678+0x1111_1111, cin=1 → 0x2345_678A.
- NBYTES=1 build: 0x80+0x80, cin=0 → sum=0x00, cout=1, ovf=1, latency 1 edge.
- MPADD_SUB_EN build, in_sub=1: 0x0000_0005−0x0000_0007 → sum=0xFFFF_FFFE, cout=0. 0x10−0x03 → 0x0000_000D, cout=1.

Source files
------------

// File: rtl/mpadd_pkg.sv
// Shared types and helpers for the byte-serial multi-precision adder.
package mpadd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The byte index needs at least one bit, even for a single-byte build.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/cla.sv
// 8-bit carry-lookahead adder shared by the byte-serial datapaths.
// Purely combinational; no handshake.
module cla (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;

    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum  = prop ^ carry[7:0];
        cout = carry[8];
    end

endmodule

// File: rtl/mpadd_seq.sv
// Byte-serial multi-precision add (LSB first) through one cla; MPADD_SUB_EN adds in_sub for A-B.
// out_valid rises NBYTES edges after accept; in_ready low while busy, result held until out_ready.
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
`ifdef MPADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   step;
    logic   last;

    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      sum_reg;
    logic [W-1:0]      sum_merge;
    logic              carry_reg;
    logic [IDX_W-1:0]  idx;
    logic              sub_reg;
    logic              cin_eff;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] s_byte;
    logic              c_byte;

`ifdef MPADD_SUB_EN
    // Subtract is A + ~B + 1, so the initial carry is forced high.
    assign cin_eff = in_sub | in_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= in_sub;
        end
    end
`else
    assign cin_eff = in_cin;
    assign sub_reg = 1'b0;
`endif

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_byte    = a_reg[idx*BYTE_W +: BYTE_W];
        b_byte    = b_reg[idx*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_reg}};
        sum_merge = sum_reg;
        sum_merge[idx*BYTE_W +: BYTE_W] = s_byte;
    end

    cla u_cla (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_reg),
        .sum  (s_byte),
        .cout (c_byte)
    );

    // Results are loaded only on the final byte so the outputs never show partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= cin_eff;
            idx       <= '0;
        end else if (step) begin
            sum_reg   <= sum_merge;
            carry_reg <= c_byte;
            if (last) begin
                out_sum  <= sum_merge;
                out_cout <= c_byte;
                out_ovf  <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                            (s_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mpadd_seq.sv
// Randomized and directed bench for mpadd_seq against a whole-word arithmetic model.
module tb_mpadd_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef MPADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mpadd_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef MPADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, cout, sum} from plain whole-word arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         ovf;
        beff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, beff} + (W+1)'(sub | cin);
        ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    task automatic rand_word(output logic [W-1:0] w);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       w = '1;
            1:       w = {1'b0, {(W-1){1'b1}}};
            2:       w = {1'b1, {(W-1){1'b0}}};
            default: w = r[W-1:0];
        endcase
    endtask

    task automatic drive_junk();
        logic [W-1:0] ja;
        logic [W-1:0] jb;
        rand_word(ja);
        rand_word(jb);
        in_valid = 1'b1;
        in_a     = ja;
        in_b     = jb;
        in_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int hold, input bit junk);
        logic [W+1:0] exp;
        int           cnt;
        exp = ref_add(a, b, cin, sub);
        check("idle_ready", 64'(in_ready), 64'(1'b1));
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef MPADD_SUB_EN
        in_sub   = sub;
`endif
        in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 4*NBYTES + 8) begin
            if (junk) drive_junk();
            tick();
            cnt++;
        end
        check("latency", 64'(cnt), 64'(NBYTES));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (junk) drive_junk();
            tick();
            check("hold_sum", 64'(out_sum), 64'(exp[W-1:0]));
            check("hold_in_ready", 64'(in_ready), 64'(1'b0));
        end
        check("out_valid", 64'(out_valid), 64'(1'b1));
        check("busy_done", 64'(busy), 64'(1'b1));
        check("sum", 64'(out_sum), 64'(exp[W-1:0]));
        check("cout", 64'(out_cout), 64'(exp[W]));
        check("ovf", 64'(out_ovf), 64'(exp[W+1]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("handoff_valid", 64'(out_valid), 64'(1'b0));
        check("handoff_ready", 64'(in_ready), 64'(1'b1));
        check("handoff_busy", 64'(busy), 64'(1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1'b1));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
        check({tag, "_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_sum"}, 64'(out_sum), 64'(0));
        check({tag, "_cout"}, 64'(out_cout), 64'(1'b0));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(1'b0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rsub;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef MPADD_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_op(W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 1'b0, 0, 1'b0);
        run_op(W'(32'hFFFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0, 0, 1'b0);
        run_op(W'(32'h7FFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0, 1, 1'b0);
        run_op(W'(32'h8000_0000), W'(32'h8000_0000), 1'b0, 1'b0, 0, 1'b0);
        run_op(W'(32'hDEAD_BEEF), W'(32'h0BAD_F00D), 1'b1, 1'b0, 10, 1'b1);

        // Abort mid-run: three edges after accept the index sits at 2.
        in_a     = W'(32'hAAAA_AAAA);
        in_b     = W'(32'h5555_5555);
        in_cin   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        tick();
        run_op(W'(32'h1234_5678), W'(32'h1111_1111), 1'b1, 1'b0, 0, 1'b0);

`ifdef MPADD_SUB_EN
        run_op(W'(32'h0000_0005), W'(32'h0000_0007), 1'b0, 1'b1, 0, 1'b0);
        run_op(W'(32'h0000_0010), W'(32'h0000_0003), 1'b1, 1'b1, 2, 1'b0);
`endif

        for (int n = 0; n < 150; n++) begin
            rand_word(ra);
            rand_word(rb);
`ifdef MPADD_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom_range(0, 1)), rsub,
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
